imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Single-port arbiter in front of the 512 x 32 instruction memory, which has a registered read and a one-cycle latency. It shares the memory between the core fetch port, which only reads, and the loader/debug port, which reads and writes. It allows exactly one memory access per cycle and routes each read response back to the requester that issued it. It also enforces a fairness limit so that a streaming loader cannot starve fetch, unless the loader has explicitly locked the memory.

## Interface
Parameters:
- ADDR_W, 9, word-address width (memory depth 2^ADDR_W)
- DATA_W, 32, instruction/data width
- MAX_BURST, 4, consecutive loader grants allowed while fetch is waiting (range 1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch requests a read this cycle
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid (registered)
- f_rdata  out  DATA_W  fetch read data; 0 when f_rvalid=0
- l_req  in  1  loader requests an access
- l_we  in  1  1 = write, 0 = read
- l_lock  in  1  while high, fetch is never granted
- l_addr  in  ADDR_W  loader word address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader request accepted this cycle (combinational)
- l_rvalid  out  1  loader read data valid (registered)
- l_rdata  out  DATA_W  loader read data; 0 when l_rvalid=0
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid the cycle after m_en && !m_we

## Operation
- Grant decision, evaluated each cycle; at most one of f_gnt and l_gnt is high:
  - l_lock=1: l_gnt=l_req and f_gnt=0.
  - Otherwise, if both request and burst_cnt < MAX_BURST: loader wins.
  - Otherwise, if both request and burst_cnt == MAX_BURST: fetch wins.
  - Otherwise, a single requester always wins.
- burst_cnt, 4 bits, updated on the clock edge:
  - l_gnt && f_req && !l_lock: increments, saturating at MAX_BURST.
  - f_gnt: clears to 0.
  - f_req=0: clears to 0.
  - Otherwise: holds.
- Memory drive:
  - m_en = f_gnt | l_gnt.
  - m_we = l_gnt & l_we.
  - m_addr and m_wdata come from the granted port.
  - When nothing is granted: m_addr=0 and m_wdata=0.
- Response tag, registered: rd_owner ∈ {NONE, FETCH, LOADER}, set each cycle from the current grant.
  - Loader writes set NONE.
- Responses:
  - f_rvalid = (rd_owner==FETCH).
  - l_rvalid = (rd_owner==LOADER).
  - The matching rdata output = m_rdata; the other port's rdata output = 0.
- Requests are not queued. A requester that is not granted must hold its request, address and data until granted.
- Writes complete in the grant cycle; no response is generated.
- A loader write followed by a fetch read of the same address in the next cycle returns the new data. This is guaranteed by memory ordering; the arbiter adds nothing.

## Timing
- Grants and memory drive: zero-cycle (combinational from the requests).
- Read data: valid exactly one cycle after the grant.
- Pipelining: back-to-back grants give one response per cycle with no bubbles.
- Reset (rst=1 at an edge):
  - rd_owner=NONE and burst_cnt=0.
  - All registered outputs are 0.
  - During rst, f_gnt, l_gnt and m_en are forced to 0.
- Reset mid-operation: a read granted in the cycle before rst produces no rvalid after reset.
- Simultaneous requests while fetch is waiting: the loader receives MAX_BURST grants, then fetch receives one grant.
- l_lock toggling: l_lock falling does not clear burst_cnt. Fairness resumes using the current count.
- Idle cycles (no request) produce no memory activity.

## Test plan
- Reset: preload memory word 5 = 0xDEADBEEF. Assert rst for 2 cycles with f_req=1 → f_gnt=0, m_en=0, f_rvalid=0. Release rst, keep f_req=1, addr=5 → f_gnt the same cycle, then f_rvalid=1 with f_rdata=0xDEADBEEF the next cycle.
- Write then read: loader writes 0x00500093 to addr 3, then fetch reads addr 3 the next cycle → f_rdata=0x00500093. l_rvalid never asserts.
- Fairness, MAX_BURST=4: f_req and l_req both held high (loader reads) → grant pattern L,L,L,L,F,L,L,L,L,F. Each l_rvalid/f_rvalid arrives one cycle after its grant with the correct owner.
- Lock: l_lock=1, both requesting for 10 cycles → 10 loader grants, f_gnt=0 throughout. On lock release, fetch is granted once burst_cnt has reached MAX_BURST.
- Back-to-back fetch: addresses 0..7 on consecutive cycles → f_rvalid high for 8 consecutive cycles with data in order, no gaps.
- Mid-flight reset: fetch granted at cycle N, rst at cycle N+1 → f_rvalid=0 at N+1 and N+2.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter and its clients:
// fetch read port, loader read/write port and the single memory port.
interface imem_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) ();
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;

   logic              l_req;
   logic              l_we;
   logic              l_lock;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_gnt;
   logic              l_rvalid;
   logic [DATA_W-1:0] l_rdata;

   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  f_req, f_addr,
      input  l_req, l_we, l_lock, l_addr, l_wdata,
      input  m_rdata,
      output f_gnt, f_rvalid, f_rdata,
      output l_gnt, l_rvalid, l_rdata,
      output m_en, m_we, m_addr, m_wdata
   );

   modport master (
      output f_req, f_addr,
      output l_req, l_we, l_lock, l_addr, l_wdata,
      output m_rdata,
      input  f_gnt, f_rvalid, f_rdata,
      input  l_gnt, l_rvalid, l_rdata,
      input  m_en, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter: fetch (read-only) vs loader (read/write),
// one access per cycle, responses routed by a registered owner tag, bounded loader bursts.
module imem_arbiter #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input logic           clk,
   input logic           rst,
   imem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOADER} owner_e;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   owner_e            owner_q, owner_d;
   logic [3:0]        burst_q, burst_d;
   logic              f_gnt, l_gnt;
   logic [ADDR_W-1:0] m_addr_c;
   logic [DATA_W-1:0] m_wdata_c;

   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (!rst) begin
         if (bus.l_lock) begin
            l_gnt = bus.l_req;
         end else if (bus.f_req && bus.l_req) begin
            if (burst_q < MAX_CNT) l_gnt = 1'b1;
            else                   f_gnt = 1'b1;
         end else begin
            f_gnt = bus.f_req;
            l_gnt = bus.l_req;
         end
      end
   end

   always_comb begin
      m_addr_c  = '0;
      m_wdata_c = '0;
      if (f_gnt) begin
         m_addr_c = bus.f_addr;
      end else if (l_gnt) begin
         m_addr_c  = bus.l_addr;
         m_wdata_c = bus.l_wdata;
      end
   end

   // Burst counter only advances while fetch is actually being held off.
   always_comb begin
      burst_d = burst_q;
      if (l_gnt && bus.f_req && !bus.l_lock) begin
         burst_d = (burst_q >= MAX_CNT) ? MAX_CNT : burst_q + 4'd1;
      end else if (f_gnt || !bus.f_req) begin
         burst_d = 4'd0;
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (f_gnt)                     owner_d = OWN_FETCH;
      else if (l_gnt && !bus.l_we)   owner_d = OWN_LOADER;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_NONE;
         burst_q <= 4'd0;
      end else begin
         owner_q <= owner_d;
         burst_q <= burst_d;
      end
   end

   assign bus.f_gnt   = f_gnt;
   assign bus.l_gnt   = l_gnt;
   assign bus.m_en    = f_gnt | l_gnt;
   assign bus.m_we    = l_gnt & bus.l_we;
   assign bus.m_addr  = m_addr_c;
   assign bus.m_wdata = m_wdata_c;

   // A read issued just before reset must not surface while reset is held.
   assign bus.f_rvalid = (owner_q == OWN_FETCH) && !rst;
   assign bus.l_rvalid = (owner_q == OWN_LOADER) && !rst;
   assign bus.f_rdata  = bus.f_rvalid ? bus.m_rdata : '0;
   assign bus.l_rdata  = bus.l_rvalid ? bus.m_rdata : '0;
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter with a behavioural memory and
// a cycle-level reference model of grants, fairness and response routing.
module tb_imem_arbiter;
   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 32;
   localparam int MAX_BURST = 4;
   localparam int DEPTH     = 1 << ADDR_W;

   logic clk;
   logic rst;
   logic preload;

   imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   // Memory: registered read, one-cycle latency; junk on m_rdata when not reading.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
         bus.m_rdata <= $urandom;
      end else begin
         if (bus.m_en && bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
         if (bus.m_en && !bus.m_we) bus.m_rdata <= mem[bus.m_addr];
         else                       bus.m_rdata <= $urandom;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int          m_cnt    = 0;
   int          pend_own = 0;   // 0 none, 1 fetch, 2 loader
   logic [31:0] pend_data = '0;

   task automatic cycle();
      int          ef, el, own_n, cnt_n;
      logic [31:0] dat_n, ea, ew, efd, eld;
      logic        fr, lr;
      #1;
      fr = bus.f_req;
      lr = bus.l_req;
      ef = 0;
      el = 0;
      if (!rst) begin
         if (bus.l_lock)    el = int'(lr);
         else if (fr && lr) begin
            if (m_cnt < MAX_BURST) el = 1;
            else                   ef = 1;
         end else begin
            ef = int'(fr);
            el = int'(lr);
         end
      end
      ea = (ef == 1) ? 32'(bus.f_addr) : (el == 1) ? 32'(bus.l_addr) : 32'd0;
      ew = (el == 1) ? bus.l_wdata : 32'd0;
      check("f_gnt",   32'(bus.f_gnt),  32'(ef));
      check("l_gnt",   32'(bus.l_gnt),  32'(el));
      check("m_en",    32'(bus.m_en),   32'(ef | el));
      check("m_we",    32'(bus.m_we),   32'((el == 1) && bus.l_we));
      check("m_addr",  32'(bus.m_addr), ea);
      check("m_wdata", bus.m_wdata,     ew);
      efd = (pend_own == 1 && !rst) ? pend_data : 32'd0;
      eld = (pend_own == 2 && !rst) ? pend_data : 32'd0;
      check("f_rvalid", 32'(bus.f_rvalid), 32'(pend_own == 1 && !rst));
      check("l_rvalid", 32'(bus.l_rvalid), 32'(pend_own == 2 && !rst));
      check("f_rdata",  bus.f_rdata, efd);
      check("l_rdata",  bus.l_rdata, eld);

      own_n = 0;
      dat_n = '0;
      if (ef == 1) begin
         own_n = 1;
         dat_n = ref_mem[bus.f_addr];
      end else if (el == 1 && !bus.l_we) begin
         own_n = 2;
         dat_n = ref_mem[bus.l_addr];
      end
      if (el == 1 && bus.l_we) ref_mem[bus.l_addr] = bus.l_wdata;

      cnt_n = m_cnt;
      if (rst)                                   cnt_n = 0;
      else if (el == 1 && fr && !bus.l_lock)     cnt_n = (m_cnt + 1 > MAX_BURST) ? MAX_BURST : m_cnt + 1;
      else if (ef == 1 || !fr)                   cnt_n = 0;

      @(posedge clk);
      pend_own  = own_n;
      pend_data = dat_n;
      m_cnt     = cnt_n;
      @(negedge clk);
   endtask

   task automatic idle();
      bus.f_req  = 1'b0;
      bus.l_req  = 1'b0;
      bus.l_we   = 1'b0;
      bus.l_lock = 1'b0;
   endtask

   initial begin
      logic [9:0] pat;
      logic [2:0] pat3;
      int         lg, fg, rv;

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
      ref_mem[5] = 32'hDEADBEEF;
      preload     = 1'b1;
      rst         = 1'b1;
      idle();
      bus.f_addr  = '0;
      bus.l_addr  = '0;
      bus.l_wdata = '0;
      @(negedge clk);
      preload = 1'b0;

      // Reset with fetch requesting
      bus.f_req  = 1'b1;
      bus.f_addr = 9'd5;
      cycle();
      cycle();
      #1;
      check("rst_f_gnt", 32'(bus.f_gnt), 32'd0);
      check("rst_m_en",  32'(bus.m_en),  32'd0);
      check("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_f_gnt", 32'(bus.f_gnt), 32'd1);
      cycle();
      bus.f_req = 1'b0;
      #1;
      check("post_rst_f_rvalid", 32'(bus.f_rvalid), 32'd1);
      check("post_rst_f_rdata",  bus.f_rdata, 32'hDEADBEEF);
      cycle();

      // Loader write followed immediately by fetch of the same word
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 9'd3; bus.l_wdata = 32'h00500093;
      cycle();
      idle();
      bus.f_req = 1'b1; bus.f_addr = 9'd3;
      #1;
      check("wr_no_l_rvalid", 32'(bus.l_rvalid), 32'd0);
      cycle();
      idle();
      #1;
      check("wr_rd_f_rdata", bus.f_rdata, 32'h00500093);
      check("wr_rd_l_rvalid", 32'(bus.l_rvalid), 32'd0);
      cycle();

      // Fairness: both held, loader reading
      bus.f_req = 1'b1; bus.l_req = 1'b1; bus.l_we = 1'b0;
      bus.f_addr = 9'd20; bus.l_addr = 9'd40;
      for (int i = 0; i < 10; i++) begin
         #1;
         pat[i] = bus.f_gnt;
         cycle();
      end
      check("fair_pattern", 32'(pat), 32'h210);

      // Two loader grants, then lock, then release: loader finishes the burst
      cycle();
      cycle();
      bus.l_lock = 1'b1;
      lg = 0; fg = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         lg += int'(bus.l_gnt);
         fg += int'(bus.f_gnt);
         cycle();
      end
      check("lock_l_gnts", 32'(lg), 32'd10);
      check("lock_f_gnts", 32'(fg), 32'd0);
      bus.l_lock = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         pat3[i] = bus.f_gnt;
         cycle();
      end
      check("unlock_pattern", 32'(pat3), 32'h4);
      idle();
      cycle();

      // Back-to-back fetch
      rv = 0;
      bus.f_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.f_addr = 9'(i);
         #1;
         if (i > 0) rv += int'(bus.f_rvalid);
         cycle();
      end
      idle();
      #1;
      rv += int'(bus.f_rvalid);
      cycle();
      check("b2b_rvalid_count", 32'(rv), 32'd8);

      // Reset arriving right after a granted fetch
      bus.f_req = 1'b1; bus.f_addr = 9'd7;
      cycle();
      idle();
      rst = 1'b1;
      #1;
      check("midrst_rvalid_n1", 32'(bus.f_rvalid), 32'd0);
      cycle();
      rst = 1'b0;
      #1;
      check("midrst_rvalid_n2", 32'(bus.f_rvalid), 32'd0);
      cycle();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bus.f_req   = $urandom_range(0, 1) == 1;
         bus.l_req   = $urandom_range(0, 1) == 1;
         bus.l_we    = $urandom_range(0, 1) == 1;
         bus.l_lock  = $urandom_range(0, 15) == 0;
         bus.f_addr  = 9'($urandom_range(0, DEPTH - 1));
         bus.l_addr  = 9'($urandom_range(0, DEPTH - 1));
         bus.l_wdata = $urandom;
         rst         = $urandom_range(0, 63) == 0;
         cycle();
      end
      rst = 1'b0;
      idle();
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
